// File: rtl/reflex_pkg.sv
// Shared types and constants for the reflex round controller.
package reflex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_TARGET = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED     = 16'hACE1;
    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [9:0]  DELAY_BASE_MS = 10'd256;
    localparam logic [6:0]  CNT_MAX       = 7'd127;
    localparam logic [9:0]  REACT_MAX     = 10'd1023;

    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        return (v == CNT_MAX) ? v : v + 7'd1;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used for delay and target draws.
module lfsr16 import reflex_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= LFSR_SEED;
        end else if (out[0]) begin
            out <= (out >> 1) ^ LFSR_TAPS;
        end else begin
            out <= out >> 1;
        end
    end

endmodule

// File: rtl/reflex_round_ctrl.sv
// Reaction-game round controller: random delay, lit target, reaction window,
// score/miss bookkeeping and a fixed-length round timer.
module reflex_round_ctrl import reflex_pkg::*; #(
    parameter int CLK_HZ      = 100000000,
    parameter int ROUND_SEC   = 30,
    parameter int NUM_TARGETS = 4,
    parameter int WINDOW_MS   = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_btn,
    input  logic [NUM_TARGETS-1:0] hit,
    output logic [NUM_TARGETS-1:0] target_led,
    output logic [4:0]             elapsed_s,
    output logic [6:0]             score,
    output logic [6:0]             miss_cnt,
    output logic [9:0]             last_react_ms,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             state_dbg
);

    localparam int MS_DIV  = CLK_HZ / 1000;
    localparam int MS_W    = $clog2(MS_DIV + 1);
    localparam int SEC_W   = $clog2(CLK_HZ + 1);
    localparam int IDX_W   = $clog2(NUM_TARGETS);
    localparam int REACT_W = $clog2(WINDOW_MS + 1);

    state_t state, state_d;

    logic [15:0]            lfsr;
    logic                   unused_lfsr_bits;
    logic [MS_W-1:0]        ms_cnt, ms_cnt_d;
    logic [SEC_W-1:0]       sec_cnt, sec_cnt_d;
    logic [9:0]             delay_cnt, delay_cnt_d;
    logic [9:0]             delay_ms, delay_ms_d;
    logic [IDX_W-1:0]       idx, idx_d;
    logic [REACT_W-1:0]     react_cnt, react_cnt_d;
    logic [NUM_TARGETS-1:0] led_d, lit_mask;
    logic [4:0]             elapsed_d;
    logic [6:0]             score_d, miss_d;
    logic [9:0]             last_d;
    logic [31:0]            react_sum;
    logic                   ms_tick, sec_tick, round_over, redraw;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr)
    );

    assign unused_lfsr_bits = ^lfsr[15:9];

    assign busy      = (state == ST_DELAY) || (state == ST_TARGET);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

    assign ms_tick    = busy && (ms_cnt == MS_W'(MS_DIV - 1));
    assign sec_tick   = busy && (sec_cnt == SEC_W'(CLK_HZ - 1));
    assign round_over = sec_tick && (elapsed_s == 5'(ROUND_SEC - 1));

    always_comb begin
        state_d     = state;
        led_d       = target_led;
        elapsed_d   = elapsed_s;
        score_d     = score;
        miss_d      = miss_cnt;
        last_d      = last_react_ms;
        ms_cnt_d    = ms_cnt;
        sec_cnt_d   = sec_cnt;
        delay_cnt_d = delay_cnt;
        delay_ms_d  = delay_ms;
        idx_d       = idx;
        react_cnt_d = react_cnt;
        redraw      = 1'b0;
        lit_mask    = '0;
        lit_mask[idx] = 1'b1;
        // A hit on a tick cycle counts that millisecond as elapsed.
        react_sum   = 32'(react_cnt) + 32'(ms_tick);

        if (busy) begin
            ms_cnt_d  = ms_tick ? '0 : ms_cnt + MS_W'(1);
            sec_cnt_d = sec_tick ? '0 : sec_cnt + SEC_W'(1);
            if (sec_tick) begin
                elapsed_d = elapsed_s + 5'd1;
            end
        end

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_btn) begin
                    score_d   = '0;
                    miss_d    = '0;
                    elapsed_d = '0;
                    last_d    = '0;
                    ms_cnt_d  = '0;
                    sec_cnt_d = '0;
                    led_d     = '0;
                    redraw    = 1'b1;
                    state_d   = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (round_over) begin
                    led_d   = '0;
                    state_d = ST_DONE;
                end else if (|hit) begin
                    miss_d = sat_inc7(miss_cnt);
                    redraw = 1'b1;
                end else if (ms_tick) begin
                    if (delay_cnt == delay_ms - 10'd1) begin
                        led_d       = lit_mask;
                        react_cnt_d = '0;
                        state_d     = ST_TARGET;
                    end else begin
                        delay_cnt_d = delay_cnt + 10'd1;
                    end
                end
            end
            ST_TARGET: begin
                if (round_over) begin
                    led_d   = '0;
                    state_d = ST_DONE;
                end else if (|hit) begin
                    if (hit == target_led) begin
                        score_d = sat_inc7(score);
                        last_d  = (react_sum > 32'(REACT_MAX)) ? REACT_MAX : react_sum[9:0];
                    end else begin
                        miss_d = sat_inc7(miss_cnt);
                    end
                    led_d   = '0;
                    redraw  = 1'b1;
                    state_d = ST_DELAY;
                end else if (ms_tick) begin
                    if (react_cnt == REACT_W'(WINDOW_MS - 1)) begin
                        miss_d  = sat_inc7(miss_cnt);
                        led_d   = '0;
                        redraw  = 1'b1;
                        state_d = ST_DELAY;
                    end else begin
                        react_cnt_d = react_cnt + REACT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (redraw) begin
            delay_ms_d  = DELAY_BASE_MS + {1'b0, lfsr[8:0]};
            idx_d       = lfsr[IDX_W-1:0];
            delay_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            target_led    <= '0;
            elapsed_s     <= '0;
            score         <= '0;
            miss_cnt      <= '0;
            last_react_ms <= '0;
            ms_cnt        <= '0;
            sec_cnt       <= '0;
            delay_cnt     <= '0;
            delay_ms      <= DELAY_BASE_MS;
            idx           <= '0;
            react_cnt     <= '0;
        end else begin
            state         <= state_d;
            target_led    <= led_d;
            elapsed_s     <= elapsed_d;
            score         <= score_d;
            miss_cnt      <= miss_d;
            last_react_ms <= last_d;
            ms_cnt        <= ms_cnt_d;
            sec_cnt       <= sec_cnt_d;
            delay_cnt     <= delay_cnt_d;
            delay_ms      <= delay_ms_d;
            idx           <= idx_d;
            react_cnt     <= react_cnt_d;
        end
    end

endmodule

// File: tb/tb_reflex_round_ctrl.sv
// Bench for reflex_round_ctrl at CLK_HZ=1000 (one cycle per millisecond),
// checked every cycle against an edge-numbered model of the game rules.
module tb_reflex_round_ctrl;
    import reflex_pkg::*;

    localparam int CLK_HZ    = 1000;
    localparam int ROUND_SEC = 30;
    localparam int NT        = 4;
    localparam int WINDOW    = 1000;
    localparam int ROUND_LEN = ROUND_SEC * CLK_HZ;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_btn = 1'b0;
    logic [NT-1:0] hit = '0;
    logic [NT-1:0] target_led;
    logic [4:0]    elapsed_s;
    logic [6:0]    score, miss_cnt;
    logic [9:0]    last_react_ms;
    logic          busy, done;
    logic [1:0]    state_dbg;

    int total = 0;
    int bad   = 0;

    // Model: edge counter e, plus round facts expressed as absolute edge numbers.
    int          e = 0;
    int          m_start, m_due, m_lit_edge, m_elapsed, m_idx;
    logic        m_busy, m_done, m_lit;
    logic [6:0]  m_score, m_miss;
    logic [9:0]  m_last;
    logic [15:0] m_lfsr = 16'hACE1;

    reflex_round_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .ROUND_SEC   (ROUND_SEC),
        .NUM_TARGETS (NT),
        .WINDOW_MS   (WINDOW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_btn     (start_btn),
        .hit           (hit),
        .target_led    (target_led),
        .elapsed_s     (elapsed_s),
        .score         (score),
        .miss_cnt      (miss_cnt),
        .last_react_ms (last_react_ms),
        .busy          (busy),
        .done          (done),
        .state_dbg     (state_dbg)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0];
        return {fb, v[15:1]} ^ {2'b00, fb, fb, 1'b0, fb, 10'b0};
    endfunction

    function automatic logic [NT-1:0] led_exp();
        return m_lit ? NT'(1 << m_idx) : '0;
    endfunction

    function automatic logic [NT-1:0] wrong_mask(input logic [NT-1:0] good);
        logic [NT-1:0] m;
        do m = NT'($urandom_range(1, 15)); while (m == good);
        return m;
    endfunction

    task automatic draw(input logic [15:0] l);
        m_due = e + 256 + int'(l[8:0]);
        m_idx = int'(l[1:0]);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance the model for the coming edge, compare all outputs.
    task automatic step(input logic s, input logic [NT-1:0] h, input logic r);
        logic [15:0] l;
        logic [34:0] exp_v, act_v;
        start_btn = s;
        hit       = h;
        rst       = r;
        l = m_lfsr;
        e++;
        if (r) begin
            m_lfsr = 16'hACE1;
            m_busy = 1'b0; m_done = 1'b0; m_lit = 1'b0;
            m_score = '0; m_miss = '0; m_last = '0; m_elapsed = 0;
        end else begin
            m_lfsr = lfsr_step(l);
            if (m_busy) begin
                if (e - m_start == ROUND_LEN) begin
                    m_busy = 1'b0; m_done = 1'b1; m_lit = 1'b0; m_elapsed = ROUND_SEC;
                end else begin
                    m_elapsed = (e - m_start) / CLK_HZ;
                    if (!m_lit) begin
                        if (h != '0) begin
                            m_miss = (m_miss == 7'd127) ? m_miss : m_miss + 7'd1;
                            draw(l);
                        end else if (e == m_due) begin
                            m_lit = 1'b1; m_lit_edge = e;
                        end
                    end else if (h != '0) begin
                        if (h == NT'(1 << m_idx)) begin
                            m_score = (m_score == 7'd127) ? m_score : m_score + 7'd1;
                            m_last  = (e - m_lit_edge > 1023) ? 10'd1023 : 10'(e - m_lit_edge);
                        end else begin
                            m_miss = (m_miss == 7'd127) ? m_miss : m_miss + 7'd1;
                        end
                        m_lit = 1'b0;
                        draw(l);
                    end else if (e - m_lit_edge == WINDOW) begin
                        m_miss = (m_miss == 7'd127) ? m_miss : m_miss + 7'd1;
                        m_lit = 1'b0;
                        draw(l);
                    end
                end
            end else if (s) begin
                m_busy = 1'b1; m_done = 1'b0; m_lit = 1'b0;
                m_score = '0; m_miss = '0; m_last = '0; m_elapsed = 0;
                m_start = e;
                draw(l);
            end
        end
        @(negedge clk);
        exp_v = {led_exp(), 5'(m_elapsed), m_score, m_miss, m_last, m_busy, m_done};
        act_v = {target_led, elapsed_s, score, miss_cnt, last_react_ms, busy, done};
        total++;
        assert (act_v === exp_v) else begin
            bad++;
            $error("FAIL cycle e=%0d: observed=%h expected=%h", e, act_v, exp_v);
        end
    endtask

    task automatic wait_lit();
        int n;
        n = 0;
        while (!m_lit && n < 1000) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        chk("lit_seen", 32'(target_led != '0), 32'd1);
    endtask

    task automatic count_delay(input string tag, input logic [15:0] l);
        int n;
        step(1'b1, '0, 1'b0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_score"}, 32'(score), 32'd0);
        chk({tag, "_miss"}, 32'(miss_cnt), 32'd0);
        n = 0;
        while (target_led == '0 && n < 1000) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        chk({tag, "_delay"}, 32'(n), 32'd256 + 32'(l[8:0]));
        chk({tag, "_idx"}, 32'(target_led), 32'd1 << l[1:0]);
    endtask

    initial begin
        logic [15:0] l0;
        logic [6:0]  sc;
        int          kind, n, r, exp_edge;

        @(negedge clk);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("rst_led", 32'(target_led), 32'd0);
        chk("rst_elapsed", 32'(elapsed_s), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_miss", 32'(miss_cnt), 32'd0);
        chk("rst_react", 32'(last_react_ms), 32'd0);
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // Round 1: first draw, three timed hits, start ignored, timeout.
        l0 = m_lfsr;
        count_delay("first", l0);
        for (int k = 0; k < 3; k++) begin
            wait_lit();
            repeat (99) step(1'b0, '0, 1'b0);
            step(1'b0, led_exp(), 1'b0);
            chk("hit_score", 32'(score), 32'(k + 1));
            chk("hit_react", 32'(last_react_ms), 32'd100);
            chk("hit_miss", 32'(miss_cnt), 32'd0);
            chk("hit_led_off", 32'(target_led), 32'd0);
        end
        step(1'b1, '0, 1'b0);
        chk("start_busy_state", 32'(state_dbg), 32'(ST_DELAY));
        chk("start_busy_score", 32'(score), 32'd3);
        wait_lit();
        repeat (999) step(1'b0, '0, 1'b0);
        chk("window_still_lit", 32'(target_led != '0), 32'd1);
        step(1'b0, '0, 1'b0);
        chk("timeout_miss", 32'(miss_cnt), 32'd1);
        chk("timeout_led", 32'(target_led), 32'd0);
        chk("timeout_state", 32'(state_dbg), 32'(ST_DELAY));

        // Reset in the middle of a lit target, then a restart from the seed.
        wait_lit();
        step(1'b0, '0, 1'b1);
        chk("midrst_outputs", 32'({target_led, elapsed_s, score, miss_cnt, busy, done}), 32'd0);
        chk("midrst_react", 32'(last_react_ms), 32'd0);
        chk("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
        l0 = 16'hACE1;
        count_delay("reseed", l0);

        // Round 2: early press, wrong button, then random play to the end.
        step(1'b0, '0, 1'b1);
        step(1'b1, '0, 1'b0);
        step(1'b0, NT'($urandom_range(1, 15)), 1'b0);
        wait_lit();
        step(1'b0, wrong_mask(led_exp()), 1'b0);
        chk("miss_two", 32'(miss_cnt), 32'd2);
        chk("miss_two_score", 32'(score), 32'd0);

        while (e < m_start + ROUND_LEN - 2600) begin
            kind = $urandom_range(0, 5);
            if (kind == 0 && !m_lit) begin
                n = $urandom_range(0, 200);
                repeat (n) step(1'b0, '0, 1'b0);
                if (!m_lit) step(1'b0, NT'($urandom_range(1, 15)), 1'b0);
            end else begin
                wait_lit();
                r = $urandom_range(1, 1100);
                for (int i = 1; i < r && m_lit; i++) step(1'b0, '0, 1'b0);
                if (m_lit) begin
                    if (kind == 1) step(1'b0, wrong_mask(led_exp()), 1'b0);
                    else step(1'b0, led_exp(), 1'b0);
                end
            end
        end

        // Steer play so a target is lit when the round timer expires.
        exp_edge = m_start + ROUND_LEN;
        while (e + 1 < exp_edge) begin
            if (m_lit && m_lit_edge + WINDOW < exp_edge) step(1'b0, led_exp(), 1'b0);
            else step(1'b0, '0, 1'b0);
        end
        chk("pre_expiry_lit", 32'(target_led != '0), 32'd1);
        sc = m_score;
        step(1'b0, led_exp(), 1'b0);
        chk("expiry_score", 32'(score), 32'(sc));
        chk("expiry_elapsed", 32'(elapsed_s), 32'd30);
        chk("expiry_done", 32'({busy, done}), 32'd1);
        chk("expiry_led", 32'(target_led), 32'd0);
        chk("expiry_state", 32'(state_dbg), 32'(ST_DONE));
        repeat (50) step(1'b0, NT'($urandom_range(0, 15)), 1'b0);
        chk("done_hold_score", 32'(score), 32'(sc));
        chk("done_hold_elapsed", 32'(elapsed_s), 32'd30);

        step(1'b1, '0, 1'b0);
        chk("restart_clear", 32'({elapsed_s, score, miss_cnt, last_react_ms}), 32'd0);
        chk("restart_busy", 32'({busy, done}), 32'd2);
        repeat (20) step(1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reflex_round_ctrl.md
REFLEX_ROUND_CTRL -- requirements
Module: reflex_round_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100000000, clock frequency; the millisecond tick equals CLK_HZ/1000 cycles.
REQ-002 Parameter ROUND_SEC, default 30, round length in seconds.
REQ-003 Parameter NUM_TARGETS, default 4, number of target LEDs/buttons; SHALL be a power of two, 2..8.
REQ-004 Parameter WINDOW_MS, default 1000, reaction window in ms.
REQ-005 Port clk, input, 1, system clock; all logic on rising edge.
REQ-006 Port rst, input, 1, reset; synchronous, active-high.
REQ-007 Port start_btn, input, 1, debounced single-cycle start pulse.
REQ-008 Port hit, input, NUM_TARGETS, debounced single-cycle button pulses, one bit per target.
REQ-009 Port target_led, output, NUM_TARGETS, one-hot lit target; zero when no target is lit.
REQ-010 Port elapsed_s, output, 5, whole seconds since round start.
REQ-011 Port score, output, 7, correct hits this round.
REQ-012 Port miss_cnt, output, 7, misses this round.
REQ-013 Port last_react_ms, output, 10, reaction time of the most recent correct hit.
REQ-014 Port busy, output, 1, high while a round is active; port done, output, 1, high in DONE.

Function
REQ-015 FSM states SHALL be IDLE, DELAY, TARGET and DONE.
REQ-016 IDLE/DONE + start_btn: clear score, miss_cnt, elapsed_s, last_react_ms and the ms/second prescalers; draw a delay; go to DELAY.
REQ-017 Delay draw SHALL be delay_ms = 256 + lfsr[8:0] (256..767 ms).
REQ-018 Target index SHALL be lfsr[log2(NUM_TARGETS)-1:0], latched on the same cycle as the delay draw.
REQ-019 DELAY: count ms ticks; at delay_ms, set target_led to the one-hot latched index, clear the reaction counter, go to TARGET.
REQ-020 DELAY + any hit bit (early press): miss_cnt +1, redraw delay and index, stay in DELAY.
REQ-021 TARGET + hit exactly equal to target_led: score +1, last_react_ms = reaction counter, target_led = 0 next cycle, redraw, go to DELAY.
REQ-022 TARGET + hit nonzero and not equal to target_led (wrong or multiple buttons): miss_cnt +1, target_led = 0, redraw, go to DELAY.
REQ-023 TARGET + reaction counter reaching WINDOW_MS with no hit: miss_cnt +1, target_led = 0, redraw, go to DELAY.
REQ-024 score and miss_cnt SHALL saturate at 127; last_react_ms SHALL saturate at 1023.
REQ-025 elapsed_s SHALL increment every CLK_HZ cycles while busy; on reaching ROUND_SEC the FSM SHALL go to DONE from any state on that cycle, with target_led = 0.
REQ-026 Round expiry SHALL take priority: a hit on the expiry cycle SHALL be discarded.
REQ-027 start_btn SHALL be ignored while busy.
REQ-028 DONE SHALL hold score, miss_cnt, elapsed_s and last_react_ms until start_btn or rst.
REQ-029 busy = DELAY or TARGET; done = DONE; both SHALL be registered state decodes with no combinational path from inputs.
REQ-030 A 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, SHALL advance every cycle in all states.

Reset
REQ-031 rst SHALL force IDLE; target_led, elapsed_s, score, miss_cnt, last_react_ms, busy and done = 0; LFSR = 16'hACE1; all prescalers = 0.
REQ-032 rst mid-round SHALL abort with no score retained; rst SHALL take priority over all inputs.

Structure
REQ-033 Package reflex_pkg SHALL hold the state enum, LFSR seed and taps, and the delay base constant 256.
REQ-034 LFSR SHALL be a sub-module lfsr16 (clk, rst, out[15:0]); timers and FSM remain in reflex_round_ctrl.

Verification (CLK_HZ=1000, so 1 ms = 1 cycle; bench carries an lfsr16 reference model)
REQ-035 rst, start_btn -> busy=1, score=0, miss_cnt=0; target_led one-hot exactly (256+lfsr[8:0]) cycles after the draw, index matching the model.
REQ-036 Three matching hits, each 100 cycles after target lit -> score=3, last_react_ms=100, miss_cnt=0.
REQ-037 Target lit, no hit for 1000 cycles -> miss_cnt=1, target_led=0 next cycle, state DELAY.
REQ-038 Hit during DELAY, then wrong button during TARGET -> miss_cnt=2, score=0.
REQ-039 Run 30000 cycles -> elapsed_s=30, done=1, busy=0, target_led=0; correct hit on the expiry cycle -> score unchanged; start_btn while busy -> no effect.
REQ-040 Assert rst mid-TARGET -> all outputs 0 on the next cycle, then start_btn -> delay draw matches the model reseeded at 16'hACE1.
